// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - request/result bundle between the EX stage and the multiply/divide unit
interface mult_div_unit_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        busy;
   logic        md_start;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, rs_val, rt_val,
      input  busy, md_start, hi, lo
   );

   modport slave (
      input  start, op, rs_val, rt_val,
      output busy, md_start, hi, lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle MULT/DIV unit with HI/LO registers and busy for the hazard unit
module mult_div_unit #(
   parameter int MULT_CYCLES            = 5,
   parameter int DIV_CYCLES             = 10,
   parameter bit CHECK_START_WHILE_BUSY = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   mult_div_unit_if.slave md
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_q, state_d;
   logic [3:0]  count_q, count_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic        pend_ok_q, pend_ok_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        is_signed;
   logic [63:0] mul_a, mul_b, product;
   logic [31:0] div_a, div_b, uquot, urem, quot, rem;

   // One multiplier and one divider serve both signed and unsigned forms.
   always_comb begin
      is_signed = (md.op == OP_MULT) || (md.op == OP_DIV);
      mul_a     = {(is_signed ? {32{md.rs_val[31]}} : 32'h0), md.rs_val};
      mul_b     = {(is_signed ? {32{md.rt_val[31]}} : 32'h0), md.rt_val};
      product   = mul_a * mul_b;

      // Signed divide works on magnitudes, so INT_MIN / -1 lands on 0x80000000 rem 0.
      div_a = (is_signed && md.rs_val[31]) ? (32'h0 - md.rs_val) : md.rs_val;
      div_b = (is_signed && md.rt_val[31]) ? (32'h0 - md.rt_val) : md.rt_val;
      uquot = (div_b == 32'h0) ? 32'h0 : div_a / div_b;
      urem  = (div_b == 32'h0) ? 32'h0 : div_a % div_b;
      quot  = (is_signed && (md.rs_val[31] ^ md.rt_val[31])) ? (32'h0 - uquot) : uquot;
      rem   = (is_signed && md.rs_val[31]) ? (32'h0 - urem) : urem;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         count_q   <= 4'h0;
         pend_hi_q <= 32'h0;
         pend_lo_q <= 32'h0;
         pend_ok_q <= 1'b0;
         hi_q      <= 32'h0;
         lo_q      <= 32'h0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_ok_q <= pend_ok_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_ok_d = pend_ok_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      case (state_q)
         IDLE: begin
            if (md.start) begin
               case (md.op)
                  OP_MULT, OP_MULTU: begin
                     pend_hi_d = product[63:32];
                     pend_lo_d = product[31:0];
                     pend_ok_d = 1'b1;
                     count_d   = MULT_LOAD;
                     state_d   = RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     pend_hi_d = rem;
                     pend_lo_d = quot;
                     // Divide by zero still occupies the unit but leaves HI/LO alone.
                     pend_ok_d = (md.rt_val != 32'h0);
                     count_d   = DIV_LOAD;
                     state_d   = RUN;
                  end
                  OP_MTHI: hi_d = md.rs_val;
                  OP_MTLO: lo_d = md.rs_val;
                  default: ;
               endcase
            end
         end
         RUN: begin
            count_d = count_q - 4'h1;
            if (count_q == 4'h1) begin
               state_d = IDLE;
               if (pend_ok_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign md.busy     = (state_q == RUN);
   assign md.md_start = md.start && (md.op >= OP_MULT) && (md.op <= OP_DIVU) && (state_q != RUN);
   assign md.hi       = hi_q;
   assign md.lo       = lo_q;

   generate
      if (CHECK_START_WHILE_BUSY) begin : g_start_check
         a_no_start_while_busy : assert property (
            @(posedge clk) disable iff (!rst_n)
            !(md.start && (state_q == RUN) && (md.op >= OP_MULT) && (md.op <= OP_MTLO))
         ) else $error("start accepted while busy");
      end
   endgenerate

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit against an arithmetic HI/LO model
module tb_mult_div_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mult_div_unit_if md();

   mult_div_unit #(
      .MULT_CYCLES(5),
      .DIV_CYCLES(10),
      .CHECK_START_WHILE_BUSY(1'b0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .md(md)
   );

   int errors = 0;
   int checks = 0;
   logic [31:0] hi_m = 32'h0;
   logic [31:0] lo_m = 32'h0;

   function automatic int exp_latency(input logic [2:0] op);
      if (op == 3'd1 || op == 3'd2) return 5;
      if (op == 3'd3 || op == 3'd4) return 10;
      return 0;
   endfunction

   task automatic apply_model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      longint      a, b, q, r;
      logic [63:0] p;
      case (op)
         3'd1: begin
            a = longint'($signed(rs));
            b = longint'($signed(rt));
            p = 64'(a * b);
            hi_m = p[63:32];
            lo_m = p[31:0];
         end
         3'd2: begin
            p = 64'(rs) * 64'(rt);
            hi_m = p[63:32];
            lo_m = p[31:0];
         end
         3'd3: begin
            if (rt == 32'h0) begin
            end else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
               lo_m = 32'h8000_0000;
               hi_m = 32'h0;
            end else begin
               a = longint'($signed(rs));
               b = longint'($signed(rt));
               q = a / b;
               r = a % b;
               lo_m = q[31:0];
               hi_m = r[31:0];
            end
         end
         3'd4: begin
            if (rt != 32'h0) begin
               lo_m = rs / rt;
               hi_m = rs % rt;
            end
         end
         3'd5: hi_m = rs;
         3'd6: lo_m = rs;
         default: ;
      endcase
   endtask

   // Issues one start, scrambles operands while running, returns busy-high cycle count.
   task automatic do_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        output int cycles, output logic md_seen);
      @(negedge clk);
      md.start = 1'b1;
      md.op = op;
      md.rs_val = rs;
      md.rt_val = rt;
      #1 md_seen = md.md_start;
      @(negedge clk);
      md.start = 1'b0;
      md.op = 3'd0;
      md.rs_val = $urandom;
      md.rt_val = $urandom;
      cycles = 0;
      while (md.busy === 1'b1 && cycles < 40) begin
         cycles++;
         @(negedge clk);
         md.rs_val = $urandom;
         md.rt_val = $urandom;
      end
   endtask

   task automatic test_reset();
      md.start = 1'b0;
      md.op = 3'd0;
      md.rs_val = 32'h0;
      md.rt_val = 32'h0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (md.busy !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", i, md.busy); end
         checks++;
         if (md.hi !== 32'h0) begin errors++; $display("FAIL reset_hi[%0d]: got %h expected 0", i, md.hi); end
         checks++;
         if (md.lo !== 32'h0) begin errors++; $display("FAIL reset_lo[%0d]: got %h expected 0", i, md.lo); end
      end
   endtask

   task automatic test_mult();
      int cyc;
      logic mds;
      do_op(3'd1, 32'hFFFF_FFFE, 32'd3, cyc, mds);
      apply_model(3'd1, 32'hFFFF_FFFE, 32'd3);
      checks++;
      if (mds !== 1'b1) begin errors++; $display("FAIL mult_md_start: got %b expected 1", mds); end
      checks++;
      if (cyc != 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 5", cyc); end
      checks++;
      if (md.hi !== hi_m) begin errors++; $display("FAIL mult_hi: got %h expected %h", md.hi, hi_m); end
      checks++;
      if (md.lo !== lo_m) begin errors++; $display("FAIL mult_lo: got %h expected %h", md.lo, lo_m); end
   endtask

   task automatic test_div();
      int cyc;
      logic mds;
      do_op(3'd4, 32'd100, 32'd7, cyc, mds);
      apply_model(3'd4, 32'd100, 32'd7);
      checks++;
      if (cyc != 10) begin errors++; $display("FAIL divu_busy_cycles: got %0d expected 10", cyc); end
      checks++;
      if (md.lo !== lo_m || md.hi !== hi_m) begin
         errors++; $display("FAIL divu_hilo: got %h/%h expected %h/%h", md.hi, md.lo, hi_m, lo_m);
      end
      do_op(3'd3, 32'hFFFF_FFF9, 32'd2, cyc, mds);
      apply_model(3'd3, 32'hFFFF_FFF9, 32'd2);
      checks++;
      if (md.lo !== lo_m || md.hi !== hi_m) begin
         errors++; $display("FAIL div_neg_hilo: got %h/%h expected %h/%h", md.hi, md.lo, hi_m, lo_m);
      end
   endtask

   task automatic test_mt();
      int cyc;
      logic mds;
      do_op(3'd5, 32'h1234, 32'h0, cyc, mds);
      apply_model(3'd5, 32'h1234, 32'h0);
      checks++;
      if (cyc != 0 || mds !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %0d/%b expected 0/0", cyc, mds); end
      checks++;
      if (md.hi !== hi_m) begin errors++; $display("FAIL mthi_hi: got %h expected %h", md.hi, hi_m); end

      // MTLO and a second DIV presented while a MULT is in flight must be ignored.
      @(negedge clk);
      md.start = 1'b1;
      md.op = 3'd1;
      md.rs_val = 32'h0001_0003;
      md.rt_val = 32'hFFFF_0007;
      @(negedge clk);
      cyc = (md.busy === 1'b1) ? 1 : 0;
      md.op = 3'd6;
      md.rs_val = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (md.md_start !== 1'b0) begin errors++; $display("FAIL busy_mtlo_md_start: got %b expected 0", md.md_start); end
      md.op = 3'd3;
      md.rt_val = 32'd5;
      #1;
      checks++;
      if (md.md_start !== 1'b0) begin errors++; $display("FAIL busy_div_md_start: got %b expected 0", md.md_start); end
      md.op = 3'd6;
      @(negedge clk);
      md.start = 1'b0;
      md.op = 3'd0;
      while (md.busy === 1'b1 && cyc < 40) begin
         cyc++;
         @(negedge clk);
      end
      apply_model(3'd1, 32'h0001_0003, 32'hFFFF_0007);
      checks++;
      if (cyc != 5) begin errors++; $display("FAIL busy_ignore_cycles: got %0d expected 5", cyc); end
      checks++;
      if (md.lo !== lo_m || md.hi !== hi_m) begin
         errors++; $display("FAIL busy_ignore_hilo: got %h/%h expected %h/%h", md.hi, md.lo, hi_m, lo_m);
      end
   endtask

   task automatic test_div_zero_overflow();
      int cyc;
      logic mds;
      do_op(3'd5, 32'hA, 32'h0, cyc, mds);
      apply_model(3'd5, 32'hA, 32'h0);
      do_op(3'd6, 32'hB, 32'h0, cyc, mds);
      apply_model(3'd6, 32'hB, 32'h0);
      do_op(3'd3, 32'h0000_1234, 32'h0, cyc, mds);
      apply_model(3'd3, 32'h0000_1234, 32'h0);
      checks++;
      if (cyc != 10) begin errors++; $display("FAIL divzero_busy_cycles: got %0d expected 10", cyc); end
      checks++;
      if (md.hi !== 32'hA || md.lo !== 32'hB) begin
         errors++; $display("FAIL divzero_hilo: got %h/%h expected 0000000a/0000000b", md.hi, md.lo);
      end
      do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc, mds);
      apply_model(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      checks++;
      if (md.lo !== lo_m || md.hi !== hi_m) begin
         errors++; $display("FAIL div_overflow_hilo: got %h/%h expected %h/%h", md.hi, md.lo, hi_m, lo_m);
      end
   endtask

   task automatic test_reset_mid_op();
      int cyc;
      logic mds;
      do_op(3'd5, 32'h55, 32'h0, cyc, mds);
      do_op(3'd6, 32'h66, 32'h0, cyc, mds);
      @(negedge clk);
      md.start = 1'b1;
      md.op = 3'd3;
      md.rs_val = 32'd1000;
      md.rt_val = 32'd3;
      @(negedge clk);
      md.start = 1'b0;
      md.op = 3'd0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      hi_m = 32'h0;
      lo_m = 32'h0;
      checks++;
      if (md.busy !== 1'b0 || md.hi !== 32'h0 || md.lo !== 32'h0) begin
         errors++; $display("FAIL async_reset: got busy=%b hi=%h lo=%h expected 0/0/0", md.busy, md.hi, md.lo);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      checks++;
      if (md.busy !== 1'b0 || md.hi !== 32'h0 || md.lo !== 32'h0) begin
         errors++; $display("FAIL reset_discard: got busy=%b hi=%h lo=%h expected 0/0/0", md.busy, md.hi, md.lo);
      end
      do_op(3'd2, 32'hFFFF_FFFF, 32'd2, cyc, mds);
      apply_model(3'd2, 32'hFFFF_FFFF, 32'd2);
      checks++;
      if (cyc != 5 || md.hi !== hi_m || md.lo !== lo_m) begin
         errors++; $display("FAIL multu_after_reset: got %0d %h/%h expected 5 %h/%h", cyc, md.hi, md.lo, hi_m, lo_m);
      end
   endtask

   task automatic test_random();
      int cyc;
      logic mds;
      logic [2:0] op;
      logic [31:0] rs, rt;
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         rs = $urandom;
         rt = $urandom;
         case ($urandom_range(0, 7))
            0: rt = 32'h0;
            1: rt = 32'hFFFF_FFFF;
            2: rs = 32'h8000_0000;
            3: rt = 32'($urandom_range(1, 20));
            default: ;
         endcase
         do_op(op, rs, rt, cyc, mds);
         apply_model(op, rs, rt);
         checks++;
         if (cyc != exp_latency(op)) begin
            errors++; $display("FAIL rand_cycles[%0d] op=%0d: got %0d expected %0d", i, op, cyc, exp_latency(op));
         end
         checks++;
         if (mds !== ((op >= 3'd1 && op <= 3'd4) ? 1'b1 : 1'b0)) begin
            errors++; $display("FAIL rand_md_start[%0d] op=%0d: got %b", i, op, mds);
         end
         checks++;
         if (md.hi !== hi_m || md.lo !== lo_m) begin
            errors++; $display("FAIL rand_hilo[%0d] op=%0d rs=%h rt=%h: got %h/%h expected %h/%h",
                               i, op, rs, rt, md.hi, md.lo, hi_m, lo_m);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_mt();
      test_div_zero_overflow();
      test_reset_mid_op();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
